// File: rtl/intersection_traffic_model.sv
// Street-side traffic model: per-street car queues fed by LFSR/injected arrivals, drained on green.
// Define SAFETY_CHECK_EN to build the lamp legality / phase-order monitor.
module intersection_traffic_model #(
  parameter int         Q_W    = 4,
  parameter logic [4:0] SEED_A = 5'b00001,
  parameter logic [4:0] SEED_B = 5'b10101
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rand_en,
  input  logic           car_a,
  input  logic           car_b,
  input  logic           RA,
  input  logic           YA,
  input  logic           GA,
  input  logic           RB,
  input  logic           YB,
  input  logic           GB,
  output logic           TA,
  output logic           TB,
  output logic [Q_W-1:0] q_a,
  output logic [Q_W-1:0] q_b,
  output logic           ovf_a,
  output logic           ovf_b,
  output logic           viol,
  output logic [1:0]     viol_code
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [4:0] INIT_A = (SEED_A == 5'd0) ? 5'd1 : SEED_A;
  localparam logic [4:0] INIT_B = (SEED_B == 5'd0) ? 5'd1 : SEED_B;

  logic [4:0] lfsr_a, lfsr_b;
  logic       arr_a, arr_b, dep_a, dep_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_a <= INIT_A;
      lfsr_b <= INIT_B;
    end else begin
      lfsr_a <= {lfsr_a[3:0], lfsr_a[4] ^ lfsr_a[2]};
      lfsr_b <= {lfsr_b[3:0], lfsr_b[4] ^ lfsr_b[2]};
    end
  end

  assign arr_a = (rand_en && (lfsr_a[1:0] == 2'b11)) || car_a;
  assign arr_b = (rand_en && (lfsr_b[1:0] == 2'b11)) || car_b;
  assign dep_a = GA && (q_a != '0);
  assign dep_b = GB && (q_b != '0);

  // Simultaneous arrival and departure leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a   <= '0;
      ovf_a <= 1'b0;
    end else if (arr_a && !dep_a) begin
      if (&q_a) ovf_a <= 1'b1;
      else      q_a   <= q_a + 1'b1;
    end else if (dep_a && !arr_a) begin
      q_a <= q_a - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_b   <= '0;
      ovf_b <= 1'b0;
    end else if (arr_b && !dep_b) begin
      if (&q_b) ovf_b <= 1'b1;
      else      q_b   <= q_b + 1'b1;
    end else if (dep_b && !arr_b) begin
      q_b <= q_b - 1'b1;
    end
  end

  assign TA = (q_a != '0);
  assign TB = (q_b != '0);

`ifdef SAFETY_CHECK_EN
  typedef enum logic [2:0] {INIT, P0, P1, P2, P3} mon_state_t;

  mon_state_t state, next_state, phase;
  logic       legal, allowed, viol_event, viol_r;
  logic [1:0] event_code, code_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Lamp order in the pattern is {RA,YA,GA,RB,YB,GB}.
  always_comb begin
    phase   = INIT;
    legal   = 1'b1;
    allowed = 1'b1;
    case ({RA, YA, GA, RB, YB, GB})
      6'b001100: phase = P0;
      6'b010100: phase = P1;
      6'b100001: phase = P2;
      6'b100010: phase = P3;
      default:   legal = 1'b0;
    endcase
    case (state)
      P0:      allowed = (phase == P0) || (phase == P1);
      P1:      allowed = (phase == P1) || (phase == P2);
      P2:      allowed = (phase == P2) || (phase == P3);
      P3:      allowed = (phase == P3) || (phase == P0);
      default: allowed = 1'b1;
    endcase
    next_state = (legal && allowed) ? phase : INIT;
  end

  always_comb begin
    viol_event = !legal || !allowed;
    event_code = !legal ? 2'b01 : 2'b10;
  end

  // Only the first violation is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_r <= 1'b0;
      code_r <= 2'b00;
    end else if (viol_event && !viol_r) begin
      viol_r <= 1'b1;
      code_r <= event_code;
    end
  end

  assign viol      = viol_r;
  assign viol_code = code_r;
`else
  logic unused_lamps;
  assign unused_lamps = ^{RA, YA, RB, YB};
  assign viol         = 1'b0;
  assign viol_code    = 2'b00;
`endif

endmodule

// File: tb/tb_intersection_traffic_model.sv
// Directed self-checking bench for intersection_traffic_model (queues, overflow, LFSR arrivals, monitor).
module tb_intersection_traffic_model;

  localparam int Q_W = 4;

  logic           clk = 1'b0;
  logic           rst, rand_en, car_a, car_b;
  logic           RA, YA, GA, RB, YB, GB;
  logic           TA, TB, ovf_a, ovf_b, viol;
  logic [Q_W-1:0] q_a, q_b;
  logic [1:0]     viol_code;

  int checks = 0;
  int passed = 0;
  int cur_phase = 0;

  intersection_traffic_model #(
    .Q_W(Q_W), .SEED_A(5'b00001), .SEED_B(5'b10101)
  ) dut (
    .clk(clk), .rst(rst), .rand_en(rand_en), .car_a(car_a), .car_b(car_b),
    .RA(RA), .YA(YA), .GA(GA), .RB(RB), .YB(YB), .GB(GB),
    .TA(TA), .TB(TB), .q_a(q_a), .q_b(q_b), .ovf_a(ovf_a), .ovf_b(ovf_b),
    .viol(viol), .viol_code(viol_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setPhase(input int p);
    case (p)
      0:       {RA, YA, GA, RB, YB, GB} = 6'b001100;
      1:       {RA, YA, GA, RB, YB, GB} = 6'b010100;
      2:       {RA, YA, GA, RB, YB, GB} = 6'b100001;
      default: {RA, YA, GA, RB, YB, GB} = 6'b100010;
    endcase
  endtask

  // Walk through the legal phase order, one edge per intermediate phase.
  task automatic goPhase(input int target);
    while (cur_phase != target) begin
      cur_phase = (cur_phase + 1) % 4;
      setPhase(cur_phase);
      if (cur_phase != target) step(1);
    end
  endtask

  task automatic applyStimulus(input logic ca, input logic cb, input logic re);
    car_a   = ca;
    car_b   = cb;
    rand_en = re;
  endtask

  task automatic applyReset(input int phase);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    cur_phase = phase;
    setPhase(phase);
    step(2);
    rst = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " q_a"}, int'(q_a), 0);
    checkOutput({tag, " q_b"}, int'(q_b), 0);
    checkOutput({tag, " TA"}, int'(TA), 0);
    checkOutput({tag, " TB"}, int'(TB), 0);
    checkOutput({tag, " ovf_a"}, int'(ovf_a), 0);
    checkOutput({tag, " ovf_b"}, int'(ovf_b), 0);
    checkOutput({tag, " viol"}, int'(viol), 0);
    checkOutput({tag, " viol_code"}, int'(viol_code), 0);
  endtask

  initial begin
    $display("[TB] start");

    applyReset(0);
    checkResetValues("reset");
    step(10);
    checkOutput("idle q_a", int'(q_a), 0);
    checkOutput("idle q_b", int'(q_b), 0);
    checkOutput("idle TA", int'(TA), 0);
    checkOutput("idle TB", int'(TB), 0);
    checkOutput("idle viol", int'(viol), 0);

    // Three injected cars on red A, then drain one per edge on green A.
    goPhase(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fill q_a", int'(q_a), 3);
    checkOutput("fill TA", int'(TA), 1);
    goPhase(0);
    step(1);
    checkOutput("drain1 q_a", int'(q_a), 2);
    step(1);
    checkOutput("drain2 q_a", int'(q_a), 1);
    step(1);
    checkOutput("drain3 q_a", int'(q_a), 0);
    checkOutput("drain3 TA", int'(TA), 0);

    // On green, a steady stream holds one car in the queue (arrive + depart).
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(3);
    checkOutput("green stream q_a", int'(q_a), 1);
    checkOutput("green stream TA", int'(TA), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(2);
    checkOutput("preload q_a", int'(q_a), 0);
    checkOutput("preload q_b", int'(q_b), 2);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Fill A to capacity on red while B arrivals cancel B departures.
    goPhase(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(15);
    checkOutput("full q_a", int'(q_a), 15);
    checkOutput("full ovf_a", int'(ovf_a), 0);
    checkOutput("balance q_b", int'(q_b), 2);
    step(1);
    checkOutput("ovf q_a", int'(q_a), 15);
    checkOutput("ovf ovf_a", int'(ovf_a), 1);
    checkOutput("ovf q_b", int'(q_b), 2);
    checkOutput("ovf ovf_b", int'(ovf_b), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // One full LFSR period yields 8 random arrivals (states ending in 2'b11).
    for (int run = 0; run < 2; run++) begin
      applyReset(2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      step(31);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("lfsr run%0d q_a", run), int'(q_a), 8);
    end

`ifdef SAFETY_CHECK_EN
    applyReset(0);
    step(1);
    for (int p = 1; p <= 4; p++) begin
      goPhase(p % 4);
      step(1);
    end
    checkOutput("legal cycle viol", int'(viol), 0);
    setPhase(2);
    cur_phase = 2;
    step(1);
    checkOutput("skip viol", int'(viol), 1);
    checkOutput("skip viol_code", int'(viol_code), 2);
    {RA, YA, GA, RB, YB, GB} = 6'b001001;
    step(1);
    checkOutput("sticky viol", int'(viol), 1);
    checkOutput("sticky viol_code", int'(viol_code), 2);
`endif

    // Both greens at once; a mid-run reset must clear everything.
    applyReset(0);
    step(1);
    {RA, YA, GA, RB, YB, GB} = 6'b001001;
    step(1);
`ifdef SAFETY_CHECK_EN
    checkOutput("both green viol", int'(viol), 1);
    checkOutput("both green viol_code", int'(viol_code), 1);
`else
    checkOutput("both green viol", int'(viol), 0);
    checkOutput("both green viol_code", int'(viol_code), 0);
`endif
    {RA, YA, GA, RB, YB, GB} = 6'b001100;
    applyStimulus(1'b1, 1'b1, 1'b0);
    step(2);
    checkOutput("pre-reset q_b", int'(q_b), 2);
    checkOutput("pre-reset TB", int'(TB), 1);
    rst = 1'b1;
    #1;
    checkResetValues("mid reset");
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
